branch_trap_unit: RTL and testbench

Branch/trap resolution stage sitting directly downstream of the ID-stage comparer in the dynamic pipeline CPU. It consumes `is_branch` and `is_teq` and owns the fetch PC register. It redirects fetch on taken beq/bne/bgez and on eret. For a taken teq, it runs a multi-cycle trap-entry sequence that writes EPC and Cause into CP0 through a request/acknowledge handshake, then vectors to the exception handler.

---
 rtl/branch_trap_unit_if.sv | 34 +++
 rtl/branch_trap_unit.sv | 106 ++++++++++
 tb/tb_branch_trap_unit.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/branch_trap_unit_if.sv
// Signal bundle between the ID-stage comparer/CP0 side and the branch/trap unit.
// The master drives ID-stage info and CP0 acks; the slave drives fetch PC, flushes and CP0 writes.
interface branch_trap_unit_if;
    logic        stall;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [15:0] id_imm16;
    logic        branch_op;
    logic        teq_op;
    logic        eret_op;
    logic        is_branch;
    logic        is_teq;
    logic [31:0] epc_in;
    logic        cp0_ack;
    logic [31:0] pc_out;
    logic        if_flush;
    logic        id_flush;
    logic        busy;
    logic        cp0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;

    modport master (
        output stall, id_valid, id_pc, id_imm16, branch_op, teq_op, eret_op,
               is_branch, is_teq, epc_in, cp0_ack,
        input  pc_out, if_flush, id_flush, busy, cp0_we, cp0_addr, cp0_wdata
    );

    modport slave (
        input  stall, id_valid, id_pc, id_imm16, branch_op, teq_op, eret_op,
               is_branch, is_teq, epc_in, cp0_ack,
        output pc_out, if_flush, id_flush, busy, cp0_we, cp0_addr, cp0_wdata
    );
endinterface

// File: rtl/branch_trap_unit.sv
// Branch/trap resolution: owns the fetch PC, redirects on taken branches and eret,
// and runs the teq trap-entry sequence (EPC write, Cause write, vector).
module branch_trap_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0040_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0040_0004,
    parameter logic [4:0]  TR_EXCCODE = 5'd13
) (
    input  logic               clk,
    input  logic               rst,
    branch_trap_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, T_EPC, T_CAUSE, T_JUMP} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] r_epc;

    logic        w_resolve;
    logic        w_teq_taken;
    logic        w_eret;
    logic        w_br_taken;
    logic [31:0] w_br_target;

    // Priority inside a resolve event: teq > eret > taken branch.
    assign w_resolve   = bus.id_valid & ~bus.stall & (r_state == IDLE);
    assign w_teq_taken = w_resolve & bus.teq_op & bus.is_teq;
    assign w_eret      = w_resolve & bus.eret_op & ~w_teq_taken;
    assign w_br_taken  = w_resolve & bus.branch_op & bus.is_branch & ~w_teq_taken & ~bus.eret_op;
    assign w_br_target = bus.id_pc + 32'd4 + {{14{bus.id_imm16[15]}}, bus.id_imm16, 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
            r_epc   <= 32'd0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_teq_taken) begin
                r_epc <= bus.id_pc;
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_pc_next     = r_pc;
        bus.if_flush  = 1'b0;
        bus.id_flush  = 1'b0;
        bus.busy      = 1'b0;
        bus.cp0_we    = 1'b0;
        bus.cp0_addr  = 5'd0;
        bus.cp0_wdata = 32'd0;
        case (r_state)
            IDLE: begin
                if (w_teq_taken) begin
                    w_state_next = T_EPC;
                    bus.if_flush = 1'b1;
                    bus.id_flush = 1'b1;
                    w_pc_next    = r_pc + 32'd4;
                end else if (w_eret) begin
                    bus.if_flush = 1'b1;
                    w_pc_next    = bus.epc_in;
                end else if (w_br_taken) begin
                    bus.if_flush = 1'b1;
                    w_pc_next    = w_br_target;
                end else if (!bus.stall) begin
                    w_pc_next = r_pc + 32'd4;
                end
            end
            T_EPC: begin
                bus.busy      = 1'b1;
                bus.if_flush  = 1'b1;
                bus.cp0_we    = 1'b1;
                bus.cp0_addr  = 5'd14;
                bus.cp0_wdata = r_epc;
                if (bus.cp0_ack) begin
                    w_state_next = T_CAUSE;
                end
            end
            T_CAUSE: begin
                bus.busy      = 1'b1;
                bus.if_flush  = 1'b1;
                bus.cp0_we    = 1'b1;
                bus.cp0_addr  = 5'd13;
                bus.cp0_wdata = {25'd0, TR_EXCCODE, 2'b00};
                if (bus.cp0_ack) begin
                    w_state_next = T_JUMP;
                end
            end
            T_JUMP: begin
                bus.busy     = 1'b1;
                bus.if_flush = 1'b1;
                w_pc_next    = EXC_VECTOR;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign bus.pc_out = r_pc;
endmodule

// File: tb/tb_branch_trap_unit.sv
// Directed bench for branch_trap_unit: reset, branches, stalls, teq trap with late acks,
// eret and reset in the middle of a trap sequence.
module tb_branch_trap_unit;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   busy_cycles;

    branch_trap_unit_if bus ();

    branch_trap_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.stall     = 1'b0;
        bus.id_valid  = 1'b0;
        bus.id_pc     = 32'd0;
        bus.id_imm16  = 16'd0;
        bus.branch_op = 1'b0;
        bus.teq_op    = 1'b0;
        bus.eret_op   = 1'b0;
        bus.is_branch = 1'b0;
        bus.is_teq    = 1'b0;
        bus.epc_in    = 32'd0;
        bus.cp0_ack   = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        idle_inputs();
        rst = 1'b1;

        // Reset
        tick();
        tick();
        chk("reset_pc", bus.pc_out, 32'h0040_0000);
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_cp0_we", {31'd0, bus.cp0_we}, 32'd0);
        chk("reset_if_flush", {31'd0, bus.if_flush}, 32'd0);
        $display("reset pc=%h", bus.pc_out);
        rst = 1'b0;
        tick();
        chk("free_pc1", bus.pc_out, 32'h0040_0004);
        tick();
        chk("free_pc2", bus.pc_out, 32'h0040_0008);
        tick();
        chk("free_pc3", bus.pc_out, 32'h0040_000C);
        $display("free-run pc=%h", bus.pc_out);

        // Taken beq while stalled: no flush, PC held
        bus.id_valid  = 1'b1;
        bus.id_pc     = 32'h0040_0010;
        bus.id_imm16  = 16'hFFFC;
        bus.branch_op = 1'b1;
        bus.is_branch = 1'b1;
        bus.stall     = 1'b1;
        #3;
        chk("beq_stall_flush", {31'd0, bus.if_flush}, 32'd0);
        tick();
        chk("beq_stall_pc", bus.pc_out, 32'h0040_000C);
        $display("beq stalled pc=%h", bus.pc_out);

        // Taken beq: backward target 0x00400010 + 4 - 16
        bus.stall = 1'b0;
        #3;
        chk("beq_if_flush", {31'd0, bus.if_flush}, 32'd1);
        chk("beq_id_flush", {31'd0, bus.id_flush}, 32'd0);
        tick();
        chk("beq_pc", bus.pc_out, 32'h0040_0004);
        $display("beq taken pc=%h", bus.pc_out);

        // Not-taken bne, then 3 stalled cycles
        bus.is_branch = 1'b0;
        #3;
        chk("bne_nt_flush", {31'd0, bus.if_flush}, 32'd0);
        tick();
        chk("bne_nt_pc", bus.pc_out, 32'h0040_0008);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold_pc", bus.pc_out, 32'h0040_0008);
        end
        $display("bne not-taken + stall pc=%h", bus.pc_out);

        // Not-taken teq is sequential
        bus.stall     = 1'b0;
        bus.branch_op = 1'b0;
        bus.teq_op    = 1'b1;
        bus.is_teq    = 1'b0;
        #3;
        chk("teq_nt_flush", {31'd0, bus.if_flush}, 32'd0);
        tick();
        chk("teq_nt_pc", bus.pc_out, 32'h0040_000C);
        chk("teq_nt_busy", {31'd0, bus.busy}, 32'd0);
        $display("teq not-taken pc=%h", bus.pc_out);

        // Taken teq, each ack two cycles late
        bus.id_pc  = 32'h0040_0020;
        bus.is_teq = 1'b1;
        #3;
        chk("teq_if_flush", {31'd0, bus.if_flush}, 32'd1);
        chk("teq_id_flush", {31'd0, bus.id_flush}, 32'd1);
        chk("teq_detect_busy", {31'd0, bus.busy}, 32'd0);
        tick();
        idle_inputs();
        busy_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            bus.cp0_ack = (i == 2);
            #3;
            chk("epc_we", {31'd0, bus.cp0_we}, 32'd1);
            chk("epc_addr", {27'd0, bus.cp0_addr}, 32'd14);
            chk("epc_data", bus.cp0_wdata, 32'h0040_0020);
            if (bus.busy) busy_cycles++;
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            bus.cp0_ack = (i == 2);
            #3;
            chk("cause_we", {31'd0, bus.cp0_we}, 32'd1);
            chk("cause_addr", {27'd0, bus.cp0_addr}, 32'd13);
            chk("cause_data", bus.cp0_wdata, 32'h0000_0034);
            chk("trap_hold_pc", bus.pc_out, 32'h0040_0010);
            if (bus.busy) busy_cycles++;
            tick();
        end
        bus.cp0_ack = 1'b0;
        #3;
        chk("jump_we", {31'd0, bus.cp0_we}, 32'd0);
        chk("jump_addr", {27'd0, bus.cp0_addr}, 32'd0);
        chk("jump_if_flush", {31'd0, bus.if_flush}, 32'd1);
        if (bus.busy) busy_cycles++;
        tick();
        chk("trap_busy_cycles", busy_cycles, 32'd7);
        chk("trap_vector_pc", bus.pc_out, 32'h0040_0004);
        chk("trap_done_busy", {31'd0, bus.busy}, 32'd0);
        $display("teq trap busy=%0d pc=%h", busy_cycles, bus.pc_out);

        // eret
        bus.id_valid = 1'b1;
        bus.eret_op  = 1'b1;
        bus.epc_in   = 32'h0040_0024;
        #3;
        chk("eret_if_flush", {31'd0, bus.if_flush}, 32'd1);
        chk("eret_id_flush", {31'd0, bus.id_flush}, 32'd0);
        tick();
        chk("eret_pc", bus.pc_out, 32'h0040_0024);
        $display("eret pc=%h", bus.pc_out);

        // Reset while in T_CAUSE
        idle_inputs();
        bus.id_valid = 1'b1;
        bus.id_pc    = 32'h0040_0030;
        bus.teq_op   = 1'b1;
        bus.is_teq   = 1'b1;
        tick();
        idle_inputs();
        bus.cp0_ack = 1'b1;
        tick();
        bus.cp0_ack = 1'b0;
        #1;
        chk("abort_pre_we", {31'd0, bus.cp0_we}, 32'd1);
        chk("abort_pre_addr", {27'd0, bus.cp0_addr}, 32'd13);
        rst = 1'b1;
        #1;
        chk("abort_we", {31'd0, bus.cp0_we}, 32'd0);
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_pc", bus.pc_out, 32'h0040_0000);
        tick();
        rst = 1'b0;
        bus.cp0_ack = 1'b1;
        tick();
        chk("abort_no_resume", {31'd0, bus.busy}, 32'd0);
        chk("abort_resume_pc", bus.pc_out, 32'h0040_0004);
        $display("reset mid-trap pc=%h", bus.pc_out);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
